enqueue_packer: RTL

Next-generation message packer for the serial link TX path. Collects variable-length AXI-Stream-style messages, splits each into fixed-size blocks, and inserts a block control bit marking the first block of each message. It packs consecutive messages into one frame of `NumBlocks` blocks. A frame is released on full, no-fit, runtime-programmable timeout, or explicit flush. A one-deep output register lets accumulation continue while the link stalls.

---
 rtl/enqueue_packer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/enqueue_packer.sv
// Message packer: cuts strobe-sized messages into control-tagged blocks and packs them
// into NumBlocks-block frames, sealed on full, no-fit, timeout or flush.
module enqueue_packer #(
   parameter int DataWidth    = 64,
   parameter int StrbSize     = DataWidth / 8,
   parameter int BlockSize    = 9,
   parameter int NumBlocks    = 16,
   parameter int MaxInBlocks  = (DataWidth + BlockSize - 2) / (BlockSize - 1),
   parameter int TimeoutWidth = 8,
   parameter bit AllowVarLen  = 1'b1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [TimeoutWidth-1:0]           cfg_timeout_i,
   input  logic                              flush_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   input  logic [DataWidth-1:0]              data_i,
   input  logic [StrbSize-1:0]               strb_i,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic [NumBlocks*BlockSize-1:0]    data_o,
   output logic [$clog2(NumBlocks+1)-1:0]    num_blocks_o,
   output logic                              busy_o
);
   localparam int P    = BlockSize - 1;
   localparam int OccW = $clog2(NumBlocks + 1);
   localparam int SumW = $clog2(NumBlocks + MaxInBlocks + 1);
   localparam int PadW = MaxInBlocks * P;

   if (BlockSize < 2 || NumBlocks < MaxInBlocks || (DataWidth % 8) != 0) begin : g_bad_cfg
      $error("enqueue_packer: illegal parameter combination");
   end

   logic [NumBlocks-1:0][BlockSize-1:0] r_acc, w_acc_nxt;
   logic [OccW-1:0]                     r_occ, w_occ_nxt, w_base;
   logic [TimeoutWidth-1:0]             r_age;
   logic                                r_valid;
   logic [NumBlocks*BlockSize-1:0]      r_data;
   logic [OccW-1:0]                     r_num;

   int                                  w_nb;
   logic                                w_run;
   logic [SumW-1:0]                     w_req, w_sum;
   logic [PadW-1:0]                     w_pad;
   logic w_occ_nz, w_out_free, w_full, w_fit, w_to, w_seal, w_seal_nov, w_accept;

   // Message size in blocks: only the contiguous run of strobe ones from bit 0 counts.
   always_comb begin
      w_nb  = 0;
      w_run = 1'b1;
      for (int i = 0; i < StrbSize; i++) begin
         if (w_run && strb_i[i]) w_nb = w_nb + 1;
         else                    w_run = 1'b0;
      end
      if (!AllowVarLen || w_nb == StrbSize) w_req = SumW'(MaxInBlocks);
      else if (w_nb == 0)                   w_req = SumW'(1);
      else                                  w_req = SumW'((8 * w_nb + P - 1) / P);
   end

   assign w_sum      = SumW'(r_occ) + w_req;
   assign w_fit      = (w_sum <= SumW'(NumBlocks));
   assign w_occ_nz   = (r_occ != '0);
   assign w_out_free = ~r_valid | ready_i;
   assign w_full     = (r_occ == OccW'(NumBlocks));
   assign w_to       = (cfg_timeout_i != '0) && (r_age >= cfg_timeout_i);
   assign w_seal     = w_occ_nz & w_out_free & (w_full | (valid_i & ~w_fit) | w_to | flush_i);
   // Same as w_seal with valid_i taken as 1, so ready_o never depends on valid_i.
   assign w_seal_nov = w_occ_nz & w_out_free & (w_full | ~w_fit | w_to | flush_i);
   assign ready_o    = w_fit | w_seal_nov;
   assign w_accept   = valid_i & ready_o;
   assign w_base     = w_seal ? '0 : r_occ;

   always_comb begin
      w_pad = '0;
      w_pad[DataWidth-1:0] = data_i;
      w_acc_nxt = w_seal ? '0 : r_acc;
      if (w_accept) begin
         for (int j = 0; j < NumBlocks; j++) begin
            for (int k = 0; k < MaxInBlocks; k++) begin
               if (SumW'(j) == SumW'(w_base) + SumW'(k) && SumW'(k) < w_req)
                  w_acc_nxt[j] = {w_pad[k*P +: P], (k == 0)};
            end
         end
      end
   end

   always_comb begin
      w_occ_nxt = w_seal ? '0 : r_occ;
      if (w_accept) w_occ_nxt = OccW'(SumW'(w_base) + w_req);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acc   <= '0;
         r_occ   <= '0;
         r_age   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_num   <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         r_occ <= w_occ_nxt;
         if (!w_occ_nz || w_seal) r_age <= '0;
         else if (r_age != '1)    r_age <= r_age + 1'b1;
         if (w_seal) begin
            r_valid <= 1'b1;
            r_data  <= r_acc;
            r_num   <= r_occ;
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign valid_o      = r_valid;
   assign data_o       = r_data;
   assign num_blocks_o = r_num;
   assign busy_o       = w_occ_nz | r_valid;
endmodule
